// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with
// a fixed number of wait states. Define DMEM_PARITY_EN to store a parity bit per word.
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic        inj_par_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              inj;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_in, op;
    logic              accept;
    logic              commit;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign accept = req_valid && req_ready;
    assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, inj: inj_par_err};

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign op = (state_q == IDLE) ? req_in : req_q;

    // No memory update while reset is held.
    assign wr_en = rst_n && commit && op.write;

    // Next-state and commit-strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, handshake flags and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            if (accept) begin
                req_q <= req_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (commit) begin
            rsp_rdata <= op.write ? '0 : mem[op.addr];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[op.addr] <= op.wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_par[op.addr] <= (^op.wdata) ^ op.inj;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (commit) begin
            rsp_err <= !op.write && ((^mem[op.addr]) != mem_par[op.addr]);
        end
    end
`else
    logic unused_inj;

    assign unused_inj = op.inj;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted between request acceptance and the response (legal 0..15).
REQ-002 The module SHALL have parameter DEPTH, default 128, meaning the number of 32-bit words addressed by req_addr[6:0].
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port req_valid, input, 1, initiator request present.
REQ-006 The module SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 The module SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-008 The module SHALL have port req_addr, input, 7, word address.
REQ-009 The module SHALL have port req_wdata, input, 32, write data.
REQ-010 The module SHALL have port inj_par_err, input, 1, which inverts the stored parity of a write (used only with DMEM_PARITY_EN).
REQ-011 The module SHALL have port rsp_valid, output, 1, response present.
REQ-012 The module SHALL have port rsp_ready, input, 1, initiator consumes the response.
REQ-013 The module SHALL have port rsp_rdata, output, 32, read data; 0 for write responses.
REQ-014 The module SHALL have port rsp_err, output, 1, parity error on the returned read word.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, with req_ready = 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_write, req_addr, req_wdata and inj_par_err are latched on that edge.
REQ-017 On acceptance the FSM SHALL enter WAIT with the counter loaded to WAIT_CYCLES-1, or go directly to RESP when WAIT_CYCLES = 0.
REQ-018 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL enter RESP on the edge where the counter equals 0.
REQ-019 A write SHALL update the memory on the edge entering RESP; a read SHALL capture the memory word into rsp_rdata on that same edge.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, first asserted WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 rsp_rdata and rsp_err SHALL remain stable while rsp_valid = 1 && rsp_ready = 0.
REQ-022 On an edge with rsp_valid && rsp_ready the FSM SHALL return to IDLE; req_ready SHALL rise in the following cycle (no same-cycle re-accept), giving a minimum of WAIT_CYCLES+2 cycles per transaction.
REQ-023 A read issued after a completed write to the same address SHALL return the written data.
REQ-024 req_valid asserted outside IDLE SHALL be ignored, with no side effects.
REQ-025 rsp_ready asserted while not in RESP SHALL be ignored.

Reset
REQ-026 While rst_n = 0: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and req_ready = 1 once rst_n = 1.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction; a write aborted before its commit edge SHALL leave memory unchanged.
REQ-028 Memory contents (and parity bits) SHALL NOT be cleared by reset.

Configuration
REQ-029 With DMEM_PARITY_EN defined: each word SHALL store an even-parity bit computed from wdata XOR inj_par_err; each read SHALL recompute parity and set rsp_err = 1 on mismatch (data still returned).
REQ-030 Without DMEM_PARITY_EN: no parity storage SHALL exist, rsp_err SHALL be tied to 0, and inj_par_err SHALL be ignored.

Verification
REQ-031 Reset: rst_n = 0 for 3 cycles -> rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 after release.
REQ-032 WAIT_CYCLES = 2: write addr 0x05 data 0xDEADBEEF, rsp_ready = 1 -> rsp_valid on the 3rd cycle after acceptance, rsp_rdata = 0; then read 0x05 -> 0xDEADBEEF.
REQ-033 Backpressure: read with rsp_ready = 0 for 4 cycles -> rsp_valid and rsp_rdata held constant; req_valid pulses in that window are not accepted; req_ready = 1 one cycle after the rsp_ready handshake.
REQ-034 WAIT_CYCLES = 0: write 0x7F = 0x00000001, read 0x7F -> rsp_valid 1 cycle after each acceptance, read data 0x00000001 (address wrap boundary 0x7F).
REQ-035 Reset mid-write: accept write 0x10 = 0x12345678 over previous 0xAAAAAAAA, assert rst_n = 0 in WAIT -> subsequent read 0x10 returns 0xAAAAAAAA.
REQ-036 DMEM_PARITY_EN: write 0x20 = 0x0F0F0F0F with inj_par_err = 1, read -> rsp_err = 1 and data 0x0F0F0F0F; rewrite with inj_par_err = 0 -> rsp_err = 0.
